// File: rtl/decodifica_hamming.sv
// Hamming(15,11) single-error-correcting decoder.
// Two-stage valid/ready pipeline: stage 1 registers the codeword and its
// syndrome, stage 2 corrects the flagged bit and extracts the 11 data bits.
// A saturating counter tracks how many delivered words needed a correction.
module decodifica_hamming #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [14:0]      entrada,
  input  logic             entrada_valid,
  output logic             entrada_ready,
  output logic [10:0]      saida,
  output logic             erro,
  output logic [3:0]       posicao_erro,
  output logic             saida_valid,
  input  logic             saida_ready,
  input  logic             limpa_contador,
  output logic [CNT_W-1:0] cont_corrigidos
);

  // Syndrome: XOR of the positions (1..15) of every set bit.
  function automatic logic [3:0] calc_sindrome(input logic [14:0] cw);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 15; i++) begin
      s = s ^ ({4{cw[i]}} & 4'(i + 1));
    end
    return s;
  endfunction

  // Flip the bit named by the syndrome, then keep only the data positions.
  // A syndrome that names a parity position leaves the data untouched.
  function automatic logic [10:0] corrige_dados(input logic [14:0] cw,
                                                input logic [3:0]  s);
    logic [14:0] c;
    c = cw;
    if (s != 4'd0) begin
      c[s - 4'd1] = ~c[s - 4'd1];
    end
    return {c[14:8], c[6:4], c[2]};
  endfunction

  // Counter increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic        av;
  logic [14:0] cw_p1;
  logic [3:0]  sind_p1;
  logic        vld_p1;
  logic [10:0] dados_p1;

  // Whole pipeline advances together whenever the output slot is free.
  assign av            = !saida_valid || saida_ready;
  assign entrada_ready = av;
  assign dados_p1      = corrige_dados(cw_p1, sind_p1);

  // ---- stage 1: capture codeword and syndrome ----
  // Stage-1 valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (av) begin
      vld_p1 <= entrada_valid;
    end
  end

  // Stage-1 data; only meaningful while vld_p1 is set, so it is not reset.
  always_ff @(posedge clk) begin
    if (av) begin
      cw_p1   <= entrada;
      sind_p1 <= calc_sindrome(entrada);
    end
  end

  // ---- stage 2: correction and output registers ----
  // Output registers, cleared on reset so no stale word is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      saida_valid  <= 1'b0;
      saida        <= '0;
      erro         <= 1'b0;
      posicao_erro <= '0;
    end else if (av) begin
      saida_valid  <= vld_p1;
      saida        <= dados_p1;
      erro         <= (sind_p1 != 4'd0);
      posicao_erro <= sind_p1;
    end
  end

  // Count delivered corrected words; clear takes priority over increment.
  always_ff @(posedge clk) begin
    if (rst || limpa_contador) begin
      cont_corrigidos <= '0;
    end else if (saida_valid && saida_ready && erro) begin
      cont_corrigidos <= sat_inc(cont_corrigidos);
    end
  end

endmodule

// File: tb/tb_decodifica_hamming.sv
// Bench for decodifica_hamming: directed vectors plus random traffic checked
// against a position-arithmetic Hamming model and an in-order scoreboard.
// A second instance with a 2-bit counter shares the stimulus.
module tb_decodifica_hamming;

  typedef struct {
    logic [10:0] d;
    logic        e;
    logic [3:0]  p;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [14:0] entrada;
  logic        entrada_valid;
  logic        entrada_ready;
  logic [10:0] saida;
  logic        erro;
  logic [3:0]  posicao_erro;
  logic        saida_valid;
  logic        saida_ready;
  logic        limpa_contador;
  logic [15:0] cont16;

  logic        entrada_ready2;
  logic [10:0] saida2;
  logic        erro2;
  logic [3:0]  posicao_erro2;
  logic        saida_valid2;
  logic [1:0]  cont2;

  int   n_cmp = 0;
  int   n_err = 0;
  int   m16 = 0;
  int   m2 = 0;
  exp_t q[$];
  logic last_in_f;

  decodifica_hamming u_dut (
    .clk(clk), .rst(rst), .entrada(entrada), .entrada_valid(entrada_valid),
    .entrada_ready(entrada_ready), .saida(saida), .erro(erro),
    .posicao_erro(posicao_erro), .saida_valid(saida_valid),
    .saida_ready(saida_ready), .limpa_contador(limpa_contador),
    .cont_corrigidos(cont16)
  );

  decodifica_hamming #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .entrada(entrada), .entrada_valid(entrada_valid),
    .entrada_ready(entrada_ready2), .saida(saida2), .erro(erro2),
    .posicao_erro(posicao_erro2), .saida_valid(saida_valid2),
    .saida_ready(saida_ready), .limpa_contador(limpa_contador),
    .cont_corrigidos(cont2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_pow2(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  // Encoder: data fills non-power-of-two positions in ascending order,
  // parity at position p covers every other position sharing bit p.
  function automatic logic [14:0] enc(input logic [10:0] d);
    logic [14:0] c;
    int k;
    logic par;
    c = '0;
    k = 0;
    for (int pos = 1; pos <= 15; pos++) begin
      if (!is_pow2(pos)) begin
        c[pos-1] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= 8; p = p * 2) begin
      par = 1'b0;
      for (int pos = 1; pos <= 15; pos++) begin
        if ((pos & p) != 0 && pos != p) par = par ^ c[pos-1];
      end
      c[p-1] = par;
    end
    return c;
  endfunction

  // Reference decode: syndrome is the XOR of the positions of set bits.
  function automatic exp_t model(input logic [14:0] w);
    exp_t r;
    int s;
    int k;
    s = 0;
    for (int pos = 1; pos <= 15; pos++) begin
      if (w[pos-1]) s = s ^ pos;
    end
    if (s != 0) w[s-1] = ~w[s-1];
    r.d = '0;
    k = 0;
    for (int pos = 1; pos <= 15; pos++) begin
      if (!is_pow2(pos)) begin
        r.d[k] = w[pos-1];
        k++;
      end
    end
    r.e = (s != 0);
    r.p = 4'(s);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, score after it.
  task automatic tick();
    logic in_f, out_f, stall;
    logic [14:0] w;
    logic [10:0] s0;
    logic e0;
    logic [3:0] p0;
    exp_t x;
    #2;
    in_f  = (entrada_valid && entrada_ready && !rst) === 1'b1;
    out_f = (saida_valid && saida_ready && !rst) === 1'b1;
    stall = (saida_valid && !saida_ready && !rst) === 1'b1;
    w = entrada;
    s0 = saida; e0 = erro; p0 = posicao_erro;
    if (stall) chk("stall_ready", entrada_ready, 0);
    if (out_f) begin
      if (q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        x = q.pop_front();
        chk("out_data", saida, x.d);
        chk("out_erro", erro, x.e);
        chk("out_pos", posicao_erro, x.p);
        if (x.e) begin
          m16 = (m16 == 65535) ? 65535 : m16 + 1;
          m2  = (m2 == 3) ? 3 : m2 + 1;
        end
      end
    end
    if (rst || limpa_contador) begin
      m16 = 0;
      m2 = 0;
    end
    @(posedge clk);
    #1;
    last_in_f = in_f;
    if (in_f) q.push_back(model(w));
    if (stall) begin
      chk("stall_valid", saida_valid, 1);
      chk("stall_data", saida, s0);
      chk("stall_erro", erro, e0);
      chk("stall_pos", posicao_erro, p0);
    end
    chk("cnt16", cont16, m16);
    chk("cnt2", cont2, m2);
    chk("dut2_valid", saida_valid2, saida_valid);
    chk("dut2_ready", entrada_ready2, entrada_ready);
    if (saida_valid === 1'b1) begin
      chk("dut2_data", saida2, saida);
      chk("dut2_erro", erro2, erro);
      chk("dut2_pos", posicao_erro2, posicao_erro);
    end
  endtask

  // Single word into an empty pipeline; checks the two-edge latency.
  task automatic direct(input string tag, input logic [14:0] w, input logic [10:0] d,
                        input logic e, input logic [3:0] p);
    entrada = w;
    entrada_valid = 1'b1;
    saida_ready = 1'b1;
    tick();
    chk({tag, "_lat1"}, saida_valid, 0);
    entrada_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, saida_valid, 1);
    chk({tag, "_data"}, saida, d);
    chk({tag, "_erro"}, erro, e);
    chk({tag, "_pos"}, posicao_erro, p);
    tick();
  endtask

  task automatic drain();
    entrada_valid = 1'b0;
    saida_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [10:0] dat;
    logic [14:0] cw;
    logic [14:0] words[5];
    int idx;
    int c0;

    rst = 1'b1;
    entrada = '0;
    entrada_valid = 1'b0;
    saida_ready = 1'b1;
    limpa_contador = 1'b0;
    tick();
    tick();
    chk("rst_valid", saida_valid, 0);
    chk("rst_data", saida, 0);
    chk("rst_erro", erro, 0);
    chk("rst_pos", posicao_erro, 0);
    rst = 1'b0;

    // Directed vectors
    direct("t1_zero", 15'h0000, 11'h000, 1'b0, 4'd0);
    direct("t2_ones", 15'h7FFF, 11'h7FF, 1'b0, 4'd0);
    direct("t2_pos6", 15'h7FDF, 11'h7FF, 1'b1, 4'd6);
    direct("t3_par1", 15'h0001, 11'h000, 1'b1, 4'd1);

    // Every single-bit flip of one random codeword, back to back
    dat = 11'($urandom);
    cw = enc(dat);
    c0 = m16;
    for (int i = 0; i < 15; i++) begin
      entrada = cw ^ (15'd1 << i);
      entrada_valid = 1'b1;
      saida_ready = 1'b1;
      tick();
      if (q.size() > 0) begin
        chk("sweep_pos_model", q[q.size()-1].p, i + 1);
        chk("sweep_data_model", q[q.size()-1].d, dat);
      end
    end
    drain();
    chk("sweep_cnt15", cont16, c0 + 15);

    // Backpressure: output stalled for three cycles mid-stream
    for (int i = 0; i < 5; i++) words[i] = enc(11'($urandom)) ^ (15'($urandom_range(0, 1)) << $urandom_range(0, 14));
    idx = 0;
    for (int cyc = 0; cyc < 30 && (idx < 5 || q.size() != 0); cyc++) begin
      entrada_valid = (idx < 5);
      entrada = words[idx % 5];
      saida_ready = !(cyc >= 3 && cyc <= 5);
      tick();
      if (last_in_f) idx++;
    end
    chk("bp_all_sent", idx, 5);
    drain();

    // Random traffic: clean, single-error and arbitrary words
    idx = 0;
    entrada = enc(11'($urandom));
    for (int cyc = 0; cyc < 60; cyc++) begin
      entrada_valid = ($urandom_range(0, 3) != 0);
      saida_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_in_f) begin
        idx++;
        case ($urandom_range(0, 2))
          0: entrada = enc(11'($urandom));
          1: entrada = enc(11'($urandom)) ^ (15'd1 << $urandom_range(0, 14));
          default: entrada = 15'($urandom);
        endcase
      end
    end
    drain();

    // Narrow counter saturation, then clear racing an erroneous delivery
    limpa_contador = 1'b1;
    tick();
    limpa_contador = 1'b0;
    for (int i = 0; i < 5; i++) begin
      entrada = enc(11'($urandom)) ^ (15'd1 << $urandom_range(0, 14));
      entrada_valid = 1'b1;
      saida_ready = 1'b1;
      tick();
    end
    drain();
    chk("cnt2_sat", cont2, 3);
    entrada = enc(11'($urandom)) ^ (15'd1 << 3);
    entrada_valid = 1'b1;
    saida_ready = 1'b0;
    tick();
    entrada_valid = 1'b0;
    tick();
    tick();
    chk("clr_pending", saida_valid, 1);
    saida_ready = 1'b1;
    limpa_contador = 1'b1;
    tick();
    limpa_contador = 1'b0;
    chk("clr_cnt2", cont2, 0);
    chk("clr_cnt16", cont16, 0);

    // Reset with two words in flight
    entrada = enc(11'($urandom)) ^ 15'h0100;
    entrada_valid = 1'b1;
    tick();
    entrada = enc(11'($urandom)) ^ 15'h0010;
    tick();
    chk("inflight_valid", saida_valid, 1);
    entrada_valid = 1'b0;
    saida_ready = 1'b0;
    rst = 1'b1;
    tick();
    q.delete();
    chk("rst2_valid", saida_valid, 0);
    chk("rst2_data", saida, 0);
    chk("rst2_erro", erro, 0);
    chk("rst2_pos", posicao_erro, 0);
    chk("rst2_cnt", cont16, 0);
    rst = 1'b0;
    saida_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst2_no_stale", saida_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
